data_table_search: RTL and testbench
====================================

DATA_TABLE_SEARCH -- requirements
Module: data_table_search

Interface
REQ-001 SHALL have parameter A_WIDTH, default TABLE_ADDR_WIDTH, data-table address width.
REQ-002 SHALL have parameter MAX_HOPS, default 2**A_WIDTH, chain-walk limit before error.
REQ-003 SHALL have port clk_i, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port task_valid_i, input, 1: search request valid.
REQ-006 SHALL have port task_ready_o, output, 1: request accepted when valid and ready are both high.
REQ-007 SHALL have port task_key_i, input, KEY_WIDTH: key to find.
REQ-008 SHALL have port task_head_ptr_i, input, A_WIDTH: bucket head address.
REQ-009 SHALL have port task_head_ptr_val_i, input, 1: bucket non-empty.
REQ-010 SHALL have port res_valid_o, output, 1: result valid.
REQ-011 SHALL have port res_ready_i, input, 1: consumer takes result.
REQ-012 SHALL have port res_code_o, output, search_res_t: FOUND / NOT_FOUND / LOOP_ERR.
REQ-013 SHALL have port res_value_o, output, VALUE_WIDTH: matched value, zero unless FOUND.
REQ-014 SHALL have port res_addr_o, output, A_WIDTH: matched entry address, zero unless FOUND.
REQ-015 SHALL have port data_table, data_table_if.master: drives rd_addr/rd_en, reads rd_data (ram_data_t), drives wr_addr/wr_data/wr_en.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, CHECK, DONE.
REQ-017 SHALL assert task_ready_o only in IDLE.
REQ-018 SHALL, on acceptance with head_ptr_val=0, go IDLE->DONE, code NOT_FOUND, with no RAM read.
REQ-019 SHALL, on acceptance with head_ptr_val=1, latch the key, load ptr=head_ptr, clear the hop counter, and go to READ.
REQ-020 SHALL, in READ, drive rd_en=1 and rd_addr=ptr for exactly one cycle, then go to CHECK.
REQ-021 SHALL treat the RAM read latency as 1 cycle: rd_data is sampled in CHECK.
REQ-022 SHALL, in CHECK on rd_data.key == latched key, go to DONE with FOUND, value=rd_data.value, addr=ptr.
REQ-023 SHALL, in CHECK on mismatch with next_ptr_val=1 and hop+1 < MAX_HOPS, set ptr=next_ptr, increment hop, and go to READ.
REQ-024 SHALL, in CHECK on mismatch with next_ptr_val=0, go to DONE with NOT_FOUND.
REQ-025 SHALL, in CHECK on mismatch with next_ptr_val=1 and hop+1 >= MAX_HOPS, go to DONE with LOOP_ERR.
REQ-026 SHALL hold res_valid_o=1 and stable result fields in DONE until res_ready_i; the handshake cycle returns to IDLE.
REQ-027 SHALL register all result outputs, with no combinational path from rd_data to outputs.
REQ-028 SHALL give latency from accept cycle t to res_valid of t+3 for a first-entry hit, plus 2 cycles per extra hop, and t+1 for an empty bucket.
REQ-029 SHALL hold wr_en at 0 and wr_addr/wr_data at 0 permanently.
REQ-030 SHALL drive rd_en low in every state except READ.
REQ-031 SHALL use a hop counter of $clog2(MAX_HOPS+1) bits that never wraps.

Reset
REQ-032 SHALL, with rst_i high at any time including mid-walk, force state IDLE, task_ready_o=0 during reset, res_valid_o=0, res_code_o=NOT_FOUND, value/addr/ptr/hop=0, and rd_en=0.
REQ-033 SHALL allow task_ready_o=1 on the first clock after rst_i deasserts; a search in flight at reset is dropped silently.

Structure
REQ-034 SHALL define KEY_WIDTH, VALUE_WIDTH, TABLE_ADDR_WIDTH, ram_data_t {key, value, next_ptr, next_ptr_val} and enum search_res_t in package hash_table.
REQ-035 SHALL keep the FSM state type local to the module.
REQ-036 SHALL be a single module with no sub-modules; the data table RAM is external, behind the interface.

Verification
REQ-037 SHALL cover: empty bucket (head_ptr_val=0, key 0x11) -> NOT_FOUND at t+1, zero rd_en pulses.
REQ-038 SHALL cover: chain A(addr 5, key 0x11) and key 0x11 -> FOUND, value=A.value, addr=5, res_valid at t+3, one rd_en pulse.
REQ-039 SHALL cover: chain 5->9->2, key at addr 2 -> FOUND, addr=2, res_valid at t+7, rd_addr sequence 5,9,2.
REQ-040 SHALL cover: 3-entry chain with no match -> NOT_FOUND at t+7.
REQ-041 SHALL cover: self-loop (addr 3, next_ptr=3) with MAX_HOPS=4 -> LOOP_ERR after exactly 4 reads.
REQ-042 SHALL cover: rst_i pulse in CHECK, then res_ready_i held low for 5 cycles on the next search -> no result from the aborted search, new result held stable 5 cycles, wr_en never 1.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table lookup path: key/value widths, RAM entry layout, result codes.
package hash_table;

  localparam int KEY_WIDTH        = 8;
  localparam int VALUE_WIDTH      = 16;
  localparam int TABLE_ADDR_WIDTH = 4;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_ptr_val;
  } ram_data_t;

  typedef enum logic [1:0] {
    NOT_FOUND = 2'd0,
    FOUND     = 2'd1,
    LOOP_ERR  = 2'd2
  } search_res_t;

endpackage

// File: rtl/data_table_if.sv
// Port bundle to the external data-table RAM (1-cycle registered read, write port unused by the searcher).
interface data_table_if;
  import hash_table::*;

  logic [TABLE_ADDR_WIDTH-1:0] rd_addr;
  logic                        rd_en;
  ram_data_t                   rd_data;
  logic [TABLE_ADDR_WIDTH-1:0] wr_addr;
  ram_data_t                   wr_data;
  logic                        wr_en;

  modport master (output rd_addr, output rd_en, input rd_data,
                  output wr_addr, output wr_data, output wr_en);
  modport slave  (input rd_addr, input rd_en, output rd_data,
                  input wr_addr, input wr_data, input wr_en);
endinterface

// File: rtl/data_table_search.sv
// Walks a hash-bucket chain in the external data table looking for a key; one search at a time.
// Latency t+3 for a head hit (+2 per extra hop), t+1 for an empty bucket; result held until res_ready_i.
module data_table_search
  import hash_table::*;
#(
  parameter int A_WIDTH  = TABLE_ADDR_WIDTH,
  parameter int MAX_HOPS = 2**A_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   task_valid_i,
  output logic                   task_ready_o,
  input  logic [KEY_WIDTH-1:0]   task_key_i,
  input  logic [A_WIDTH-1:0]     task_head_ptr_i,
  input  logic                   task_head_ptr_val_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output search_res_t            res_code_o,
  output logic [VALUE_WIDTH-1:0] res_value_o,
  output logic [A_WIDTH-1:0]     res_addr_o,
  data_table_if.master           data_table
);

  localparam int HOP_W = $clog2(MAX_HOPS + 1);

  typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

  state_t                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [A_WIDTH-1:0]     ptr_q, ptr_d;
  logic [HOP_W-1:0]       hop_q, hop_d;
  search_res_t            code_q, code_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [A_WIDTH-1:0]     addr_q, addr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      ptr_q   <= '0;
      hop_q   <= '0;
      code_q  <= NOT_FOUND;
      value_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ptr_q   <= ptr_d;
      hop_q   <= hop_d;
      code_q  <= code_d;
      value_q <= value_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ptr_d   = ptr_q;
    hop_d   = hop_q;
    code_d  = code_q;
    value_d = value_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (task_valid_i) begin
          if (task_head_ptr_val_i) begin
            key_d   = task_key_i;
            ptr_d   = task_head_ptr_i;
            hop_d   = '0;
            state_d = READ;
          end else begin
            code_d  = NOT_FOUND;
            value_d = '0;
            addr_d  = '0;
            state_d = DONE;
          end
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        // Every exit to DONE rewrites all result fields so stale data never leaks out.
        if (data_table.rd_data.key == key_q) begin
          code_d  = FOUND;
          value_d = data_table.rd_data.value;
          addr_d  = ptr_q;
          state_d = DONE;
        end else if (!data_table.rd_data.next_ptr_val) begin
          code_d  = NOT_FOUND;
          value_d = '0;
          addr_d  = '0;
          state_d = DONE;
        end else if ((int'(hop_q) + 1) < MAX_HOPS) begin
          ptr_d   = data_table.rd_data.next_ptr;
          hop_d   = hop_q + 1'b1;
          state_d = READ;
        end else begin
          code_d  = LOOP_ERR;
          value_d = '0;
          addr_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked by reset because the async reset parks the FSM in IDLE.
  assign task_ready_o = (state_q == IDLE) && !rst_i;
  assign res_valid_o  = (state_q == DONE);
  assign res_code_o   = code_q;
  assign res_value_o  = value_q;
  assign res_addr_o   = addr_q;

  assign data_table.rd_en   = (state_q == READ);
  assign data_table.rd_addr = (state_q == READ) ? ptr_q : '0;
  assign data_table.wr_en   = 1'b0;
  assign data_table.wr_addr = '0;
  assign data_table.wr_data = '0;

endmodule

// File: tb/tb_data_table_search.sv
// Directed bench for data_table_search: behavioural 1-cycle RAM plus hand-computed expectations.
module tb_data_table_search;
  import hash_table::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   task_valid = 1'b0;
  logic                   task_ready;
  logic [KEY_WIDTH-1:0]   task_key = '0;
  logic [3:0]             task_head_ptr = '0;
  logic                   task_head_ptr_val = 1'b0;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  search_res_t            res_code;
  logic [VALUE_WIDTH-1:0] res_value;
  logic [3:0]             res_addr;

  data_table_if dt ();

  data_table_search #(.A_WIDTH(4), .MAX_HOPS(4)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .task_valid_i        (task_valid),
    .task_ready_o        (task_ready),
    .task_key_i          (task_key),
    .task_head_ptr_i     (task_head_ptr),
    .task_head_ptr_val_i (task_head_ptr_val),
    .res_valid_o         (res_valid),
    .res_ready_i         (res_ready),
    .res_code_o          (res_code),
    .res_value_o         (res_value),
    .res_addr_o          (res_addr),
    .data_table          (dt)
  );

  always #5 clk = ~clk;

  ram_data_t ram [16];
  always @(posedge clk) if (dt.rd_en) dt.rd_data <= ram[dt.rd_addr];

  int       rd_cnt = 0;
  int       rd_log[$];
  bit       wr_seen = 1'b0;
  always @(negedge clk) begin
    if (dt.rd_en) begin
      rd_cnt++;
      rd_log.push_back(int'(dt.rd_addr));
    end
    if (dt.wr_en) wr_seen = 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request and returns the cycle count from the accept edge to res_valid.
  task automatic do_search(input logic [7:0] key, input logic [3:0] head, input logic hval,
                           output int lat);
    int guard;
    @(negedge clk);
    task_valid = 1'b1; task_key = key; task_head_ptr = head; task_head_ptr_val = hval;
    rd_cnt = 0; rd_log.delete();
    guard = 0;
    while (!task_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!task_ready) check_val("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    task_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!res_valid) check_val("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '{key: 8'hE0 + 8'(i), value: 16'h0100 + 16'(i), next_ptr: 4'd0, next_ptr_val: 1'b0};
    ram[5] = '{key: 8'h11, value: 16'hA5A5, next_ptr: 4'd9, next_ptr_val: 1'b1};
    ram[9] = '{key: 8'h22, value: 16'h5A5A, next_ptr: 4'd2, next_ptr_val: 1'b1};
    ram[2] = '{key: 8'h33, value: 16'h1234, next_ptr: 4'd0, next_ptr_val: 1'b0};
    ram[3] = '{key: 8'h55, value: 16'h7777, next_ptr: 4'd3, next_ptr_val: 1'b1};
    dt.rd_data = '0;

    // Reset state
    @(negedge clk);
    check_val("rst_ready", task_ready, 0);
    check_val("rst_valid", res_valid, 0);
    check_val("rst_code", res_code, NOT_FOUND);
    check_val("rst_value", res_value, 0);
    check_val("rst_addr", res_addr, 0);
    check_val("rst_rd_en", dt.rd_en, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", task_ready, 1);

    // Empty bucket
    do_search(8'h11, 4'd0, 1'b0, lat);
    check_val("empty_lat", lat, 1);
    check_val("empty_code", res_code, NOT_FOUND);
    check_val("empty_reads", rd_cnt, 0);
    check_val("empty_value", res_value, 0);
    release_result();

    // Hit on bucket head
    do_search(8'h11, 4'd5, 1'b1, lat);
    check_val("head_lat", lat, 3);
    check_val("head_code", res_code, FOUND);
    check_val("head_value", res_value, 16'hA5A5);
    check_val("head_addr", res_addr, 5);
    check_val("head_reads", rd_cnt, 1);
    release_result();
    check_val("idle_after_handshake", task_ready, 1);

    // Hit on third entry of 5->9->2
    do_search(8'h33, 4'd5, 1'b1, lat);
    check_val("chain_lat", lat, 7);
    check_val("chain_code", res_code, FOUND);
    check_val("chain_value", res_value, 16'h1234);
    check_val("chain_addr", res_addr, 2);
    check_val("chain_reads", rd_cnt, 3);
    if (rd_log.size() == 3) begin
      check_val("chain_rd0", rd_log[0], 5);
      check_val("chain_rd1", rd_log[1], 9);
      check_val("chain_rd2", rd_log[2], 2);
    end else check_val("chain_rd_log_size", rd_log.size(), 3);
    release_result();

    // Miss across the whole chain
    do_search(8'h44, 4'd5, 1'b1, lat);
    check_val("miss_lat", lat, 7);
    check_val("miss_code", res_code, NOT_FOUND);
    check_val("miss_value", res_value, 0);
    check_val("miss_addr", res_addr, 0);
    release_result();

    // Self-loop trips the hop limit after MAX_HOPS reads
    do_search(8'h66, 4'd3, 1'b1, lat);
    check_val("loop_code", res_code, LOOP_ERR);
    check_val("loop_reads", rd_cnt, 4);
    check_val("loop_lat", lat, 9);
    check_val("loop_value", res_value, 0);
    release_result();

    // Reset pulse while the FSM is in CHECK
    @(negedge clk);
    task_valid = 1'b1; task_key = 8'h33; task_head_ptr = 4'd5; task_head_ptr_val = 1'b1;
    @(negedge clk);
    task_valid = 1'b0;
    check_val("abort_in_read", dt.rd_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_rst_ready", task_ready, 0);
    check_val("abort_rst_valid", res_valid, 0);
    check_val("abort_rst_rd_en", dt.rd_en, 0);
    check_val("abort_rst_code", res_code, NOT_FOUND);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("abort_no_result", res_valid, 0);
      check_val("abort_ready", task_ready, 1);
    end

    // Next search with the consumer stalled for 5 cycles
    do_search(8'h11, 4'd5, 1'b1, lat);
    check_val("stall_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_valid", res_valid, 1);
      check_val("stall_code", res_code, FOUND);
      check_val("stall_value", res_value, 16'hA5A5);
      check_val("stall_addr", res_addr, 5);
      @(negedge clk);
    end
    release_result();
    check_val("stall_released", res_valid, 0);
    check_val("wr_en_never", wr_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
